// File: rtl/heartbeat_monitor.sv
// heartbeat_monitor
// Watches an asynchronous heartbeat line, measures every half-period and
// declares the source alive or lost. `lost` is the shutdown request and
// stays set until clr_lost is pulsed.
// Optional build macro: HB_MON_GLITCH_FILTER_EN enables a 4-sample stability
// filter between the synchronizer and the edge detector.
module heartbeat_monitor #(
    parameter int CLK_HZ     = 24000000,
    parameter int MIN_HALF   = CLK_HZ / 4,
    parameter int MAX_HALF   = CLK_HZ,
    parameter int LOCK_EDGES = 4,
    localparam int CW        = $clog2(MAX_HALF + 2) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hb_in,
    input  logic          clr_lost,
    output logic          alive,
    output logic          lost,
    output logic          fault,
    output logic          period_valid,
    output logic [CW-1:0] half_period,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_LOCKING = 2'd1,
        ST_ALIVE   = 2'd2,
        ST_LOST    = 2'd3
    } state_t;

    localparam logic [CW-1:0] MIN_C  = CW'(MIN_HALF);
    localparam logic [CW-1:0] MAX_C  = CW'(MAX_HALF);
    localparam logic [3:0]    LOCK_C = 4'(LOCK_EDGES);

    logic          r_sync1;
    logic          r_sync2;
    logic          w_level;
    logic          r_prev;
    logic          r_edge;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_good_cnt;
    state_t        r_state;
    logic          r_alive;
    logic          r_lost;
    logic          r_fault;
    logic          r_pv;
    logic [CW-1:0] r_half;

    state_t        w_state_nxt;
    logic [3:0]    w_good_nxt;
    logic          w_fault_nxt;
    logic [CW-1:0] w_n;
    logic          w_timeout;
    logic          w_good;
    logic          w_short;

    // Two-flop synchronizer for the asynchronous heartbeat line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= hb_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef HB_MON_GLITCH_FILTER_EN
    logic [2:0] r_hist;
    logic       r_filt;
    logic       w_filt;

    // Filtered level moves only when four consecutive synchronized samples agree
    always_comb begin
        if ({r_hist, r_sync2} == 4'b1111) begin
            w_filt = 1'b1;
        end else if ({r_hist, r_sync2} == 4'b0000) begin
            w_filt = 1'b0;
        end else begin
            w_filt = r_filt;
        end
    end

    // Sample history and held filter level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= 3'b000;
            r_filt <= 1'b0;
        end else begin
            r_hist <= {r_hist[1:0], r_sync2};
            r_filt <= w_filt;
        end
    end

    assign w_level = w_filt;
`else
    assign w_level = r_sync2;
`endif

    // Edge detector: registered flag marks the edge cycle (both polarities)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_prev <= w_level;
            r_edge <= w_level ^ r_prev;
        end
    end

    // Half-period counter: clears on each edge cycle, saturates at MAX_HALF
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CW{1'b0}};
        end else if (r_edge) begin
            r_cnt <= {CW{1'b0}};
        end else if (r_cnt != MAX_C) begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign w_n       = r_cnt + {{(CW-1){1'b0}}, 1'b1};
    assign w_timeout = (r_cnt == MAX_C);
    assign w_good    = r_edge && !w_timeout && (w_n >= MIN_C);
    assign w_short   = r_edge && (w_n < MIN_C);

    // Next-state, lock counter and fault decision
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_fault_nxt = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (r_edge) begin
                    w_state_nxt = ST_LOCKING;
                    w_good_nxt  = 4'd0;
                end else begin
                    w_state_nxt = ST_SEARCH;
                end
            end
            ST_LOCKING: begin
                if (w_timeout) begin
                    w_state_nxt = ST_SEARCH;
                    w_good_nxt  = 4'd0;
                end else if (w_good) begin
                    if ((r_good_cnt + 4'd1) == LOCK_C) begin
                        w_state_nxt = ST_ALIVE;
                        w_good_nxt  = 4'd0;
                    end else begin
                        w_good_nxt = r_good_cnt + 4'd1;
                    end
                end else if (w_short) begin
                    w_good_nxt = 4'd0;
                end else begin
                    w_good_nxt = r_good_cnt;
                end
            end
            ST_ALIVE: begin
                if (w_timeout || w_short) begin
                    w_state_nxt = ST_LOST;
                    w_fault_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_ALIVE;
                end
            end
            ST_LOST: begin
                if (clr_lost) begin
                    w_state_nxt = ST_SEARCH;
                    w_good_nxt  = 4'd0;
                end else begin
                    w_state_nxt = ST_LOST;
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
                w_good_nxt  = 4'd0;
            end
        endcase
    end

    // State, lock counter and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_SEARCH;
            r_good_cnt <= 4'd0;
            r_alive    <= 1'b0;
            r_lost     <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_nxt;
            r_alive    <= (w_state_nxt == ST_ALIVE);
            r_lost     <= (w_state_nxt == ST_LOST);
            r_fault    <= w_fault_nxt;
        end
    end

    // Measurement register: every edge outside SEARCH publishes N
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv   <= 1'b0;
            r_half <= {CW{1'b0}};
        end else if (r_edge && (r_state != ST_SEARCH)) begin
            r_pv   <= 1'b1;
            r_half <= w_n;
        end else begin
            r_pv   <= 1'b0;
            r_half <= r_half;
        end
    end

    assign alive        = r_alive;
    assign lost         = r_lost;
    assign fault        = r_fault;
    assign period_valid = r_pv;
    assign half_period  = r_half;
    assign state        = r_state;

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Directed, table-driven bench for heartbeat_monitor with small parameters.
module tb_heartbeat_monitor;

`ifdef HB_MON_GLITCH_FILTER_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 4;
`endif

    logic       clk;
    logic       rst_n;
    logic       hb_in;
    logic       clr_lost;
    logic       alive;
    logic       lost;
    logic       fault;
    logic       period_valid;
    logic [7:0] half_period;
    logic [1:0] state;

    int n_vec;
    int n_bad;

    heartbeat_monitor #(
        .CLK_HZ(100), .MIN_HALF(25), .MAX_HALF(100), .LOCK_EDGES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hb_in(hb_in), .clr_lost(clr_lost),
        .alive(alive), .lost(lost), .fault(fault),
        .period_valid(period_valid), .half_period(half_period), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         gap;
        bit         clr;
        logic [1:0] st;
        logic [7:0] hp;
        bit         pv;
        bit         flt;
        bit         alv;
        bit         lst;
    } vec_t;

    vec_t tbl[24];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Place a transition so that it lands `gap` cycles after the previous one,
    // then advance to the cycle where its effect is visible on the outputs.
    task automatic apply_edge(input int gap, input bit clr);
        repeat (gap - LAT - 1) tick();
        hb_in = ~hb_in;
        repeat (LAT - 1) tick();
        clr_lost = clr;
        tick();
        clr_lost = 1'b0;
    endtask

    task automatic check_outs(input string tag, input int st, input int hp,
                              input int pv, input int flt, input int alv, input int lst);
        check({tag, " state"}, int'(state), st);
        check({tag, " half_period"}, int'(half_period), hp);
        check({tag, " period_valid"}, int'(period_valid), pv);
        check({tag, " fault"}, int'(fault), flt);
        check({tag, " alive"}, int'(alive), alv);
        check({tag, " lost"}, int'(lost), lst);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit seen;
        n_vec = 0;
        n_bad = 0;

        tbl[0]  = '{50,  1'b0, 2'd1, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{50,  1'b0, 2'd1, 8'd50,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{50,  1'b0, 2'd1, 8'd50,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{50,  1'b0, 2'd1, 8'd50,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{50,  1'b0, 2'd2, 8'd50,  1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{25,  1'b0, 2'd2, 8'd25,  1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{100, 1'b0, 2'd2, 8'd100, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{24,  1'b0, 2'd3, 8'd24,  1'b1, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{50,  1'b0, 2'd3, 8'd50,  1'b1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{50,  1'b1, 2'd0, 8'd50,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{50,  1'b0, 2'd1, 8'd50,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{50,  1'b0, 2'd1, 8'd50,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{50,  1'b0, 2'd1, 8'd50,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{50,  1'b0, 2'd1, 8'd50,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{50,  1'b0, 2'd2, 8'd50,  1'b1, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{10,  1'b0, 2'd3, 8'd10,  1'b1, 1'b1, 1'b0, 1'b1};
        tbl[16] = '{50,  1'b1, 2'd0, 8'd50,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{50,  1'b0, 2'd1, 8'd50,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{24,  1'b0, 2'd1, 8'd24,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[19] = '{50,  1'b0, 2'd1, 8'd50,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[20] = '{50,  1'b0, 2'd1, 8'd50,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[21] = '{50,  1'b0, 2'd1, 8'd50,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[22] = '{50,  1'b0, 2'd2, 8'd50,  1'b1, 1'b0, 1'b1, 1'b0};
        tbl[23] = '{50,  1'b1, 2'd2, 8'd50,  1'b1, 1'b0, 1'b1, 1'b0};

        // Reset state
        rst_n    = 1'b0;
        hb_in    = 1'b0;
        clr_lost = 1'b0;
        repeat (3) tick();
        check_outs("reset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Quiet line: SEARCH ignores the saturated counter
        seen = 1'b0;
        for (int c = 0; c < 500; c++) begin
            tick();
            if (state != 2'd0 || period_valid || fault || alive || lost) seen = 1'b1;
        end
        check("quiet activity", int'(seen), 0);

        // Table: each record is one transition and its expected outputs
        for (int i = 0; i < 24; i++) begin
            apply_edge(tbl[i].gap, tbl[i].clr);
            check_outs($sformatf("v%0d", i), int'(tbl[i].st), int'(tbl[i].hp),
                       int'(tbl[i].pv), int'(tbl[i].flt), int'(tbl[i].alv), int'(tbl[i].lst));
            tick();
            check($sformatf("v%0d pv_width", i), int'(period_valid), 0);
            check($sformatf("v%0d fault_width", i), int'(fault), 0);
        end

        // Timeout from ALIVE: fault one cycle after cnt reaches MAX_HALF
        k = LAT + 1;
        while (!fault && k < 400) begin
            tick();
            k++;
        end
        check("alive_timeout delay", k, LAT + 101);
        check_outs("alive_timeout", 3, 50, 0, 1, 0, 1);
        tick();
        check("alive_timeout fault_width", int'(fault), 0);

        // clr_lost on a quiet cycle leaves LOST
        clr_lost = 1'b1;
        tick();
        clr_lost = 1'b0;
        check("clr_quiet state", int'(state), 0);
        check("clr_quiet lost", int'(lost), 0);

        // Timeout in LOCKING falls back to SEARCH without fault
        apply_edge(50, 1'b0);
        check("lock_timeout entry", int'(state), 1);
        k = LAT;
        seen = 1'b0;
        while (state == 2'd1 && k < 400) begin
            tick();
            k++;
            if (fault) seen = 1'b1;
        end
        check("lock_timeout delay", k, LAT + 101);
        check("lock_timeout state", int'(state), 0);
        check("lock_timeout fault", int'(seen), 0);

        // Relock, then a 2-cycle glitch mid half-period
        for (int e = 0; e < 5; e++) apply_edge(50, 1'b0);
        check("relock alive", int'(alive), 1);
        repeat (25) tick();
        hb_in = ~hb_in;
        repeat (2) tick();
        hb_in = ~hb_in;
        repeat (LAT) tick();
`ifdef HB_MON_GLITCH_FILTER_EN
        check_outs("glitch", 2, 50, 0, 0, 1, 0);
`else
        check_outs("glitch", 3, 2, 1, 1, 0, 1);
`endif

        // Asynchronous reset mid-operation
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_reset", 0, 0, 0, 0, 0, 0);
        hb_in = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("post_reset state", int'(state), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/heartbeat_monitor.md
# heartbeat_monitor

Receive-side partner to the LED/heartbeat blinker: watches an asynchronous heartbeat line toggling at a nominal 0.5 s half-period, measures each half-period, and declares the source alive or lost. Sits in the shutdown controller between the external heartbeat pin and the shutdown sequencer. `lost` is the sequencer's shutdown request and is sticky until cleared.

## Interface
- `CLK_HZ`, 24000000, clock frequency in Hz.
- `MIN_HALF`, CLK_HZ/4, shortest legal half-period in cycles.
- `MAX_HALF`, CLK_HZ, longest legal half-period in cycles; must be greater than MIN_HALF.
- `LOCK_EDGES`, 4, consecutive good edges required to declare alive; range 1..15.
- `CW` (localparam), ceil_log2(MAX_HALF+2)+1, width of counter and measurement.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `hb_in` in 1: heartbeat input, asynchronous to clk.
- `clr_lost` in 1: synchronous clear of LOST.
- `alive` out 1: high in ALIVE.
- `lost` out 1: high in LOST.
- `fault` out 1: one-cycle pulse on the ALIVE->LOST transition.
- `period_valid` out 1: one-cycle pulse when `half_period` updates.
- `half_period` out CW: last measured edge-to-edge distance in cycles.
- `state` out 2: SEARCH=0, LOCKING=1, ALIVE=2, LOST=3.

## Operation
- Input path: 2-flop synchronizer (reset 0), then edge detect, where an edge is the synchronized level differing from its registered previous value. Both rising and falling edges count.
- `cnt` (CW bits) clears to 0 on every edge cycle and otherwise increments, saturating at MAX_HALF.
- On an edge, N = cnt+1. A good edge has MIN_HALF <= N <= MAX_HALF. A short edge has N < MIN_HALF.
- Timeout: cnt == MAX_HALF on a cycle with no edge. An edge arriving while cnt == MAX_HALF is also treated as a timeout.
- SEARCH (after reset):
  - First edge -> LOCKING with good_cnt=0.
  - No measurement is taken and timeout is ignored.
- LOCKING:
  - Good edge: good_cnt+1. When it reaches LOCK_EDGES -> ALIVE.
  - Short edge: good_cnt=0, stay in LOCKING.
  - Timeout -> SEARCH.
- ALIVE:
  - Good edge: stay.
  - Short edge or timeout -> LOST, with `fault`=1 for that transition cycle.
- LOST:
  - All edges ignored for state purposes.
  - `clr_lost`=1 -> SEARCH.
- Measurement: on every edge outside SEARCH (including in LOST), `half_period`<=N and `period_valid` pulses.
- `clr_lost` has no effect outside LOST.
- Simultaneous `clr_lost` and edge in LOST: go to SEARCH; the edge is dropped and does not advance to LOCKING.
- Reset mid-operation returns every register to its reset value immediately, including the synchronizer.

## Timing
- Reset values:
  - state=SEARCH; `alive`, `lost`, `fault`, `period_valid` all 0.
  - `half_period`=0; cnt=0; good_cnt=0; synchronizer and previous-level flops 0.
- All outputs are registered.
- Latency: an `hb_in` transition sampled at clk edge t produces its edge event at t+2. `state`, `alive`, `lost`, `fault`, `period_valid` and `half_period` reflect it after clk edge t+3.
- Timeout outputs update on the clk edge following the cnt==MAX_HALF cycle.
- `fault` and `period_valid` are exactly one cycle wide and never repeat without a new event.

## Configuration
- `HB_MON_GLITCH_FILTER_EN` defined:
  - A 4-deep stability filter sits after the synchronizer.
  - The filtered level takes the new value only when the last 4 synchronized samples are equal and differ from it.
  - Pulses shorter than 4 cycles are rejected.
  - Adds 3 cycles to all latencies above; filter reset value is 0.
- Undefined: no filter; edge detect uses the synchronizer output directly.

## Test plan
Bench parameters: CLK_HZ=100, MIN_HALF=25, MAX_HALF=100, LOCK_EDGES=4.
- Reset, hb_in static at 0 -> state=0, all outputs 0, no pulses for 500 cycles.
- Toggle hb_in every 50 cycles:
  - 1st edge -> LOCKING.
  - From the 2nd edge, `period_valid` pulses with `half_period`=50.
  - `alive`=1 three clocks after the 5th transition.
- Locked, then hold hb_in -> 100 cycles after the last edge event: one `fault` pulse, `lost`=1, `alive`=0, state=3.
- Locked, then next edge 10 cycles after the previous one -> `half_period`=10, `fault` pulse, state=3.
- In LOST, resume 50-cycle toggling:
  - `lost` stays 1.
  - `period_valid` keeps pulsing.
  - Pulse `clr_lost` on an edge cycle -> SEARCH; relock after 5 further edges.
- Locked, inject a 2-cycle glitch mid-half-period:
  - Macro undefined -> `half_period`=2, LOST.
  - Macro defined -> no edge event, ALIVE retained.
